// File: rtl/agc_pkg.sv
// rtl/agc_pkg.sv - shared opcodes, prefix state encoding and ones'-complement add
package agc_pkg;

    localparam int AGC_W = 15;

    localparam logic [AGC_W-1:0] OP_EXTEND = 15'o6;
    localparam logic [AGC_W-1:0] OP_INHINT = 15'o4;
    localparam logic [AGC_W-1:0] OP_RELINT = 15'o3;
    localparam logic [2:0]       OPC_INDEX = 3'd5;

    typedef enum logic [1:0] {
        PFX_BASE     = 2'd0,
        PFX_PEND     = 2'd1,
        PFX_IDX_WAIT = 2'd2
    } pfx_state_t;

    // End-around carry; the folded carry can never overflow again, and -0 is kept.
    function automatic logic [AGC_W-1:0] oc_add(input logic [AGC_W-1:0] a,
                                                input logic [AGC_W-1:0] b);
        logic [AGC_W:0] raw;
        raw = {1'b0, a} + {1'b0, b};
        return raw[AGC_W-1:0] + {{(AGC_W-1){1'b0}}, raw[AGC_W]};
    endfunction

endpackage

// File: rtl/oc_adder.sv
// rtl/oc_adder.sv - combinational ones'-complement adder of parametrised width
module oc_adder
    import agc_pkg::*;
#(
    parameter int WORD_W = 15
) (
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    output logic [WORD_W-1:0] sum
);

    if (WORD_W == AGC_W) begin : g_native
        assign sum = oc_add(a, b);
    end else begin : g_generic
        logic [WORD_W:0] raw;
        assign raw = {1'b0, a} + {1'b0, b};
        assign sum = raw[WORD_W-1:0] + {{(WORD_W-1){1'b0}}, raw[WORD_W]};
    end

endmodule

// File: rtl/register.sv
// rtl/register.sv - enable-loaded register cleared to zero by asynchronous reset
module register #(
    parameter int W = 1
) (
    input  logic         clock,
    input  logic         rst_l,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clock or negedge rst_l) begin
        if (!rst_l) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/prefix_sequencer.sv
// rtl/prefix_sequencer.sv - absorbs EXTEND/INDEX/INHINT/RELINT prefixes and gates interrupts
module prefix_sequencer
    import agc_pkg::*;
#(
    parameter int WORD_W    = 15,
    parameter int K_W       = 12,
    parameter int MAX_CHAIN = 2
) (
    input  logic              clock,
    input  logic              rst_l,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_instr,
    input  logic [K_W-1:0]    in_pc,
    output logic              in_ready,
    output logic              idx_req,
    output logic [9:0]        idx_addr,
    input  logic              idx_valid,
    input  logic [WORD_W-1:0] idx_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_instr,
    output logic [K_W-1:0]    out_pc,
    output logic              out_extracode,
    output logic              out_first,
    output logic              int_ok,
    output logic              chain_fault
);

    localparam int CNT_W = $clog2(MAX_CHAIN + 1);
    localparam int OUT_W = WORD_W + K_W + 1;

    pfx_state_t        state_q, state_d;
    logic              ext_q, ext_d;
    logic [WORD_W-1:0] idx_sum_q, idx_sum_d;
    logic [CNT_W-1:0]  idx_cnt_q, idx_cnt_d;
    logic              inhint_q, inhint_d;
    logic              idx_req_q, idx_req_d;
    logic [9:0]        idx_addr_q, idx_addr_d;
    logic              chain_fault_q, chain_fault_d;
    logic              first_q, first_d;
    logic              out_valid_q, out_valid_d;

    logic [WORD_W-1:0] m;
    logic [WORD_W-1:0] acc_sum;
    logic [OUT_W-1:0]  out_word;
    logic              accept, is_extend, is_int_ctl, is_index, load;

    oc_adder #(.WORD_W(WORD_W)) u_mod_add (
        .a   (in_instr),
        .b   (idx_sum_q),
        .sum (m)
    );

    oc_adder #(.WORD_W(WORD_W)) u_acc_add (
        .a   (idx_sum_q),
        .b   (idx_data),
        .sum (acc_sum)
    );

    assign in_ready   = (state_q != PFX_IDX_WAIT) && (!out_valid_q || out_ready);
    assign accept     = in_valid && in_ready && !flush;
    assign is_extend  = (m == WORD_W'(OP_EXTEND));
    assign is_int_ctl = !ext_q && ((m == WORD_W'(OP_INHINT)) || (m == WORD_W'(OP_RELINT)));
    assign is_index   = (m[WORD_W-1 -: 3] == OPC_INDEX) && (ext_q || (m[K_W-1 -: 2] == 2'b00));
    assign load       = accept && !is_extend && !is_int_ctl && !is_index;

    always_comb begin
        state_d       = state_q;
        ext_d         = ext_q;
        idx_sum_d     = idx_sum_q;
        idx_cnt_d     = idx_cnt_q;
        inhint_d      = inhint_q;
        idx_req_d     = idx_req_q;
        idx_addr_d    = idx_addr_q;
        chain_fault_d = chain_fault_q;
        first_d       = first_q;
        out_valid_d   = out_valid_q;

        if (out_valid_q && out_ready) begin
            first_d = 1'b0;
        end
        if (out_ready) begin
            out_valid_d = 1'b0;
        end
        if (load) begin
            out_valid_d = 1'b1;
        end

        if (flush) begin
            state_d     = PFX_BASE;
            ext_d       = 1'b0;
            idx_sum_d   = '0;
            idx_cnt_d   = '0;
            idx_req_d   = 1'b0;
            out_valid_d = 1'b0;
        end else if (state_q == PFX_IDX_WAIT) begin
            if (idx_valid) begin
                idx_sum_d = acc_sum;
                idx_cnt_d = idx_cnt_q + CNT_W'(1);
                idx_req_d = 1'b0;
                state_d   = PFX_PEND;
            end
        end else if (accept) begin
            if (is_extend) begin
                ext_d     = 1'b1;
                idx_sum_d = '0;
                idx_cnt_d = '0;
            end else if (is_int_ctl) begin
                inhint_d = (m == WORD_W'(OP_INHINT));
            end else if (is_index) begin
                // A chain already at its limit is abandoned rather than fetched.
                if (idx_cnt_q == CNT_W'(MAX_CHAIN)) begin
                    chain_fault_d = 1'b1;
                    ext_d         = 1'b0;
                    idx_sum_d     = '0;
                    idx_cnt_d     = '0;
                end else begin
                    idx_req_d  = 1'b1;
                    idx_addr_d = m[9:0];
                end
            end else begin
                ext_d     = 1'b0;
                idx_sum_d = '0;
                idx_cnt_d = '0;
            end

            if (idx_req_d) begin
                state_d = PFX_IDX_WAIT;
            end else begin
                state_d = (ext_d || (idx_cnt_d != '0)) ? PFX_PEND : PFX_BASE;
            end
        end
    end

    always_ff @(posedge clock or negedge rst_l) begin
        if (!rst_l) begin
            state_q       <= PFX_BASE;
            ext_q         <= 1'b0;
            idx_sum_q     <= '0;
            idx_cnt_q     <= '0;
            inhint_q      <= 1'b1;
            idx_req_q     <= 1'b0;
            idx_addr_q    <= '0;
            chain_fault_q <= 1'b0;
            first_q       <= 1'b1;
            out_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            ext_q         <= ext_d;
            idx_sum_q     <= idx_sum_d;
            idx_cnt_q     <= idx_cnt_d;
            inhint_q      <= inhint_d;
            idx_req_q     <= idx_req_d;
            idx_addr_q    <= idx_addr_d;
            chain_fault_q <= chain_fault_d;
            first_q       <= first_d;
            out_valid_q   <= out_valid_d;
        end
    end

    register #(.W(OUT_W)) u_out_reg (
        .clock (clock),
        .rst_l (rst_l),
        .en    (load),
        .d     ({ext_q, in_pc, m}),
        .q     (out_word)
    );

    assign {out_extracode, out_pc, out_instr} = out_word;

    assign out_valid   = out_valid_q;
    assign out_first   = first_q;
    assign idx_req     = idx_req_q;
    assign idx_addr    = idx_addr_q;
    assign chain_fault = chain_fault_q;
    assign int_ok      = (state_q == PFX_BASE) && !inhint_q && !out_valid_q;

endmodule

// File: tb/tb_prefix_sequencer.sv
// tb/tb_prefix_sequencer.sv - directed self-checking bench for prefix_sequencer
module tb_prefix_sequencer;

    logic        clock = 1'b0;
    logic        rst_l;
    logic        flush;
    logic        in_valid;
    logic [14:0] in_instr;
    logic [11:0] in_pc;
    logic        in_ready;
    logic        idx_req;
    logic [9:0]  idx_addr;
    logic        idx_valid;
    logic [14:0] idx_data;
    logic        out_valid;
    logic        out_ready;
    logic [14:0] out_instr;
    logic [11:0] out_pc;
    logic        out_extracode;
    logic        out_first;
    logic        int_ok;
    logic        chain_fault;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    prefix_sequencer #(.WORD_W(15), .K_W(12), .MAX_CHAIN(2)) dut (
        .clock         (clock),
        .rst_l         (rst_l),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_instr      (in_instr),
        .in_pc         (in_pc),
        .in_ready      (in_ready),
        .idx_req       (idx_req),
        .idx_addr      (idx_addr),
        .idx_valid     (idx_valid),
        .idx_data      (idx_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .out_extracode (out_extracode),
        .out_first     (out_first),
        .int_ok        (int_ok),
        .chain_fault   (chain_fault)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0o expected %0o", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic feed(input logic [14:0] instr, input logic [11:0] pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic give_idx(input logic [14:0] data);
        idx_valid = 1'b1;
        idx_data  = data;
        tick();
        idx_valid = 1'b0;
    endtask

    initial begin
        rst_l     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        idx_valid = 1'b0;
        idx_data  = '0;
        out_ready = 1'b1;
        tick();
        tick();

        check("rst_out_valid", out_valid, 0);
        check("rst_idx_req", idx_req, 0);
        check("rst_chain_fault", chain_fault, 0);
        check("rst_out_first", out_first, 1);
        check("rst_int_ok", int_ok, 0);
        check("rst_out_instr", out_instr, 0);
        check("rst_idx_addr", idx_addr, 0);
        check("rst_in_ready", in_ready, 1);
        #2 rst_l = 1'b1;
        tick();

        // Plain word with inhint still set after reset
        feed(15'o30100, 12'o10);
        check("ca_valid", out_valid, 1);
        check("ca_instr", out_instr, 'o30100);
        check("ca_pc", out_pc, 'o10);
        check("ca_extra", out_extracode, 0);
        check("ca_first", out_first, 1);
        check("ca_int_ok", int_ok, 0);
        tick();
        check("ca_drained", out_valid, 0);
        check("ca_first_clr", out_first, 0);

        // RELINT, EXTEND, extracode target
        feed(15'o3, 12'o11);
        check("relint_int_ok", int_ok, 1);
        check("relint_not_fwd", out_valid, 0);
        feed(15'o6, 12'o12);
        check("ext_int_ok", int_ok, 0);
        check("ext_not_fwd", out_valid, 0);
        feed(15'o70100, 12'o13);
        check("xt_valid", out_valid, 1);
        check("xt_instr", out_instr, 'o70100);
        check("xt_extra", out_extracode, 1);
        check("xt_int_ok", int_ok, 0);
        tick();
        check("xt_int_ok_drain", int_ok, 1);

        // INDEX by +2
        feed(15'o50100, 12'o14);
        check("idx_req", idx_req, 1);
        check("idx_addr", idx_addr, 'o100);
        check("idx_in_ready", in_ready, 0);
        check("idx_int_ok", int_ok, 0);
        tick();
        check("idx_req_hold", idx_req, 1);
        check("idx_addr_hold", idx_addr, 'o100);
        give_idx(15'o2);
        check("idx_req_drop", idx_req, 0);
        check("idx_pend_int_ok", int_ok, 0);
        feed(15'o30100, 12'o15);
        check("idx_instr", out_instr, 'o30102);
        check("idx_extra", out_extracode, 0);
        tick();

        // INDEX by -1: end-around carry
        feed(15'o50100, 12'o16);
        give_idx(15'o77776);
        feed(15'o30100, 12'o17);
        check("neg_instr", out_instr, 'o30077);
        tick();

        // Third chained INDEX faults
        feed(15'o50100, 12'o20);
        give_idx(15'o0);
        feed(15'o50100, 12'o21);
        check("ch2_idx_req", idx_req, 1);
        give_idx(15'o0);
        feed(15'o50100, 12'o22);
        check("ch_fault", chain_fault, 1);
        check("ch_no_fwd", out_valid, 0);
        check("ch_no_req", idx_req, 0);
        check("ch_base_int_ok", int_ok, 1);

        // Flush in IDX_WAIT, late operand ignored
        feed(15'o50100, 12'o23);
        check("fl_req", idx_req, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_req_drop", idx_req, 0);
        check("fl_fault_kept", chain_fault, 1);
        give_idx(15'o5);
        check("fl_late_req", idx_req, 0);
        check("fl_late_int_ok", int_ok, 1);
        feed(15'o30100, 12'o24);
        check("fl_late_instr", out_instr, 'o30100);
        tick();

        // Flush in the same cycle as an accept
        flush = 1'b1;
        feed(15'o30200, 12'o25);
        flush = 1'b0;
        check("fl_acc_dropped", out_valid, 0);

        // Backpressure, then drain and refill together
        out_ready = 1'b0;
        feed(15'o30100, 12'o26);
        in_valid = 1'b1;
        in_instr = 15'o30200;
        in_pc    = 12'o27;
        #1;
        check("bp_in_ready", in_ready, 0);
        tick();
        check("bp_valid", out_valid, 1);
        check("bp_instr_stable", out_instr, 'o30100);
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("bp_refill_valid", out_valid, 1);
        check("bp_refill_instr", out_instr, 'o30200);
        check("bp_refill_pc", out_pc, 'o27);
        tick();
        check("bp_empty", out_valid, 0);

        // Asynchronous reset mid-chain
        feed(15'o6, 12'o30);
        feed(15'o50100, 12'o31);
        check("mr_req", idx_req, 1);
        #2 rst_l = 1'b0;
        #1;
        check("mr_req_clr", idx_req, 0);
        check("mr_fault_clr", chain_fault, 0);
        check("mr_first", out_first, 1);
        check("mr_int_ok", int_ok, 0);
        check("mr_idx_addr", idx_addr, 0);
        #3 rst_l = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prefix_sequencer.md
# prefix_sequencer

Stateful front end of the decode stage. It sits between fetch and `decode`. It absorbs the EXTEND, INDEX, INHINT and RELINT prefix and modifier words, and it applies accumulated INDEX offsets to the following word using 15-bit ones'-complement arithmetic. It forwards one modified instruction per handshake, with its extracode flag, to the decoder. It is also the single authority on when an interrupt may be taken. It generalises the two-flop EXTEND/INDEX tracking used today to parametrised widths, multi-level INDEX chains, valid/ready flow control and interrupt gating.

## Interface
- `WORD_W`, default 15: instruction/data word width.
- `K_W`, default 12: address field width, `instr[K_W-1:0]`.
- `MAX_CHAIN`, default 2: maximum consecutive INDEX words before fault.
- `clock`  in  1: single clock. All state updates on the rising edge.
- `rst_l`  in  1: reset, asynchronous and active-low.
- `flush`  in  1: synchronous. Drops all prefix state and any buffered output.
- `in_valid`  in  1: fetch word valid.
- `in_instr`  in  `WORD_W`: fetched word.
- `in_pc`  in  `K_W`: address of the fetched word.
- `in_ready`  out  1: fetch word accepted when `in_valid & in_ready`.
- `idx_req`  out  1: INDEX operand read request; held until `idx_valid`.
- `idx_addr`  out  10: operand address, taken from the modified word bits [9:0].
- `idx_valid`  in  1: operand returned this cycle.
- `idx_data`  in  `WORD_W`: operand value.
- `out_valid`  out  1: modified instruction available.
- `out_ready`  in  1: decoder accepts the instruction.
- `out_instr`  out  `WORD_W`: instruction after index modification.
- `out_pc`  out  `K_W`: `in_pc` of the forwarded word.
- `out_extracode`  out  1: the word was preceded by EXTEND.
- `out_first`  out  1: first word forwarded since reset.
- `int_ok`  out  1: an interrupt may be taken before the next accepted word.
- `chain_fault`  out  1: sticky. INDEX chain exceeded `MAX_CHAIN`; cleared only by reset.

## Operation
- Prefix state comprises `ext`, `idx_sum[WORD_W-1:0]`, `idx_cnt` and `inhint`.
- The modified word is `m = oc_add(in_instr, idx_sum)`. All classification below uses `m`.
- `oc_add` is a `WORD_W`-bit add with end-around carry. The sum −0 is kept as is.
- Classification:
  - EXTEND: `m == 'o6`. Sets `ext`. Clears `idx_sum` and `idx_cnt`. Not forwarded.
  - INHINT (`m == 'o4`) or RELINT (`m == 'o3`) with `ext` clear: sets or clears `inhint`. Not forwarded. Does not alter `idx_sum`.
  - INDEX: opcode `m[14:12] == 5` and either `ext` set, or `ext` clear with `m[11:10] == 0`.
    - Enters IDX_WAIT and issues `idx_req`.
    - On `idx_valid`, sets `idx_sum = oc_add(idx_sum_partial, idx_data)`, where `idx_sum_partial` is 0 for a fresh chain.
    - Increments `idx_cnt` and preserves `ext`.
    - If `idx_cnt` would exceed `MAX_CHAIN`, sets `chain_fault`, forwards nothing and returns to BASE.
  - Otherwise: loaded into the output register with `out_extracode = ext`. Clears `ext`, `idx_sum` and `idx_cnt`.
- States:
  - BASE: no prefix pending.
  - PEND: `ext` set or `idx_cnt > 0`.
  - IDX_WAIT: goes to PEND on `idx_valid`.
- `in_ready = (state != IDX_WAIT) & (!out_valid | out_ready)`.
- `int_ok = (state == BASE) & !inhint & !out_valid`. An interrupt is never allowed between a prefix and its target.
- Output register:
  - Loads on an accepted non-prefix word.
  - Clears on `out_ready` when no new load occurs.
  - On a simultaneous load and drain, the new word replaces the old one.

## Timing
- Latency: 1 cycle from an accepted plain word to `out_valid`.
- An INDEX word costs at least 2 cycles: the accept, then ≥1 cycle in IDX_WAIT.
- Throughput: 1 word per cycle when no INDEX is involved.
- Reset values:
  - `state` = BASE, `ext` = 0, `idx_sum` = 0, `idx_cnt` = 0, `inhint` = 1.
  - `out_valid` = 0, `idx_req` = 0, `chain_fault` = 0.
  - `out_first` armed. It clears after the first `out_valid & out_ready`.
- `out_instr`, `out_pc` and `idx_addr` read 0 at reset.
- Flush:
  - Same cycle as accept: the accept is discarded.
  - In IDX_WAIT: the state goes to BASE and `idx_req` drops next cycle. A late `idx_valid` is ignored.
  - Flush does not change `inhint`, `chain_fault` or `out_first`.
- `idx_req` and `idx_addr` stay stable until `idx_valid`.
- Reset asserted mid-chain returns to reset values immediately.

## Structure
- Shared package `agc_pkg` holds:
  - constants `OP_EXTEND = 'o6`, `OP_INHINT = 'o4`, `OP_RELINT = 'o3`, `OPC_INDEX = 3'd5`;
  - the state enum `pfx_state_t`;
  - the function `oc_add`.
- Sub-module `oc_adder` (parametrised `WORD_W`, combinational) is instantiated twice: once for word modification and once for chain accumulation.
- The output register uses the existing `register` primitive.

## Test plan
- Reset, then feed `'o30100` (CA) → `out_valid` 1 cycle later with `out_instr = 'o30100`, `out_extracode = 0`, `out_first = 1`; `int_ok = 0` because `inhint = 1`.
- Feed `'o3` then `'o6` then `'o70100` → `inhint` = 0; forwarded word `'o70100` with `out_extracode = 1`; `int_ok` low from the EXTEND accept until the target drains.
- Feed `'o50100` (INDEX), return `idx_data = 'o2`, then feed `'o30100` → `idx_addr = 'o100`; `out_instr = 'o30102`.
- INDEX with `idx_data = 'o77776` (−1), then feed `'o30100` → `out_instr = 'o30077` (end-around carry).
- Issue three INDEX words with `MAX_CHAIN = 2` → `chain_fault = 1` and nothing forwarded; assert flush in IDX_WAIT → `idx_req` low next cycle and a late `idx_valid` is ignored.
- Hold `out_ready = 0` with a word in the output register → `in_ready = 0` and `out_instr` stable; release `out_ready` → drain and refill in the same cycle.
